run_tick_gen: RTL

Upstream stage of the modulo-k counter on the board: converts raw push-button inputs into a gated, single-cycle `tick` that drives the counter's `enable` input. A run/stop key toggles free-running ticks at a fixed prescale rate. A step key issues one tick on demand while stopped. The block synchronises and filters both keys so the counter advances cleanly from the 50 MHz board clock.

---
 rtl/run_tick_gen_pkg.sv | 35 +++
 rtl/run_tick_gen_if.sv | 29 ++
 rtl/run_tick_gen_key_debouncer.sv | 83 ++++++++
 rtl/run_tick_gen.sv | 96 +++++++++
 4 files changed

// File: rtl/run_tick_gen_pkg.sv
// ============================================================================
// run_tick_gen_pkg
// Shared FSM state type and width helpers for the run/step tick generator.
// Revision: 1.0
// ============================================================================
`default_nettype none

package run_tick_gen_pkg;

    typedef enum logic [0:0] {
        ST_STOPPED = 1'b0,
        ST_RUN     = 1'b1
    } run_state_t;

    // Ceiling log2; clog2(1) = 0.
    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

    // Counter width able to hold 0..value-1, never narrower than one bit.
    function automatic int width_of(input int value);
        return (clog2(value) > 1) ? clog2(value) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/run_tick_gen_if.sv
// ============================================================================
// run_tick_gen_if
// Raw key inputs and tick/running outputs of the run/step tick generator.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface run_tick_gen_if;
    logic key_run_n;
    logic key_step_n;
    logic tick;
    logic running;

    modport master (
        output key_run_n,
        output key_step_n,
        input  tick,
        input  running
    );

    modport slave (
        input  key_run_n,
        input  key_step_n,
        output tick,
        output running
    );
endinterface

`default_nettype wire

// File: rtl/run_tick_gen_key_debouncer.sv
// ============================================================================
// key_debouncer
// 2-FF synchroniser, optional stability filter (RUN_TICK_GEN_DEBOUNCE_EN)
// and one-cycle press pulse on the accepted level falling.
// Revision: 1.0
// ============================================================================
`default_nettype none

module key_debouncer
    import run_tick_gen_pkg::*;
#(
    parameter int DEBOUNCE = 1_000_000
) (
    input  logic clk,
    input  logic aclr,
    input  logic key_n,
    output logic press
);

    logic r_sync_meta;
    logic r_sync;

    always_ff @(posedge clk or negedge aclr) begin
        if (!aclr) begin
            r_sync_meta <= 1'b1;
            r_sync      <= 1'b1;
        end else begin
            r_sync_meta <= key_n;
            r_sync      <= r_sync_meta;
        end
    end

`ifdef RUN_TICK_GEN_DEBOUNCE_EN
    localparam int                 c_cnt_w = width_of(DEBOUNCE);
    localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(DEBOUNCE - 1);

    logic [c_cnt_w-1:0] r_stable_cnt;
    logic               r_level;
    logic               r_press;

    // Counts consecutive samples that disagree with the accepted level.
    always_ff @(posedge clk or negedge aclr) begin
        if (!aclr) begin
            r_stable_cnt <= '0;
            r_level      <= 1'b1;
            r_press      <= 1'b0;
        end else begin
            r_press <= 1'b0;
            if (r_sync == r_level) begin
                r_stable_cnt <= '0;
            end else if (r_stable_cnt == c_last) begin
                r_stable_cnt <= '0;
                r_level      <= r_sync;
                r_press      <= r_level;
            end else begin
                r_stable_cnt <= r_stable_cnt + 1'b1;
            end
        end
    end

    assign press = r_press;
`else
    logic r_sync_d;

    always_ff @(posedge clk or negedge aclr) begin
        if (!aclr) begin
            r_sync_d <= 1'b1;
        end else begin
            r_sync_d <= r_sync;
        end
    end

    // DEBOUNCE below 1 is illegal; such a key is left inert.
    if (DEBOUNCE >= 1) begin : g_press
        assign press = r_sync_d & ~r_sync;
    end else begin : g_press_off
        assign press = 1'b0;
    end
`endif

endmodule

`default_nettype wire

// File: rtl/run_tick_gen.sv
// ============================================================================
// run_tick_gen
// Run/stop and single-step key front end producing a one-cycle counter tick.
// Optional key filter: RUN_TICK_GEN_DEBOUNCE_EN.   Revision: 1.0
// ============================================================================
`default_nettype none

module run_tick_gen
    import run_tick_gen_pkg::*;
#(
    parameter int DIV      = 50_000_000,
    parameter int DEBOUNCE = 1_000_000
) (
    input  logic                 clk,
    input  logic                 aclr,
    run_tick_gen_if.slave        bus
);

    localparam int                 c_cnt_w = width_of(DIV);
    localparam logic [c_cnt_w-1:0] c_term  = c_cnt_w'(DIV - 1);

    logic w_run_press;
    logic w_step_press;

    key_debouncer #(.DEBOUNCE(DEBOUNCE)) u_run_key (
        .clk   (clk),
        .aclr  (aclr),
        .key_n (bus.key_run_n),
        .press (w_run_press)
    );

    key_debouncer #(.DEBOUNCE(DEBOUNCE)) u_step_key (
        .clk   (clk),
        .aclr  (aclr),
        .key_n (bus.key_step_n),
        .press (w_step_press)
    );

    run_state_t         r_state;
    run_state_t         w_state_next;
    logic [c_cnt_w-1:0] r_cnt;
    logic [c_cnt_w-1:0] w_cnt_next;
    logic               r_tick;
    logic               w_tick_next;
    logic               r_running;
    logic               w_terminal;

    assign w_terminal = (r_cnt == c_term);

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = '0;
        w_tick_next  = 1'b0;
        case (r_state)
            ST_STOPPED: begin
                // A simultaneous step press is dropped when run wins.
                if (w_run_press) begin
                    w_state_next = ST_RUN;
                end else begin
                    w_tick_next = w_step_press;
                end
            end
            ST_RUN: begin
                w_tick_next = w_terminal;
                w_cnt_next  = w_terminal ? '0 : r_cnt + 1'b1;
                if (w_run_press) begin
                    w_state_next = ST_STOPPED;
                    w_cnt_next   = '0;
                end
            end
            default: begin
                w_state_next = ST_STOPPED;
            end
        endcase
    end

    always_ff @(posedge clk or negedge aclr) begin
        if (!aclr) begin
            r_state   <= ST_STOPPED;
            r_cnt     <= '0;
            r_tick    <= 1'b0;
            r_running <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_cnt     <= w_cnt_next;
            r_tick    <= w_tick_next;
            r_running <= (w_state_next == ST_RUN);
        end
    end

    assign bus.tick    = r_tick;
    assign bus.running = r_running;

endmodule

`default_nettype wire
